keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
// - Drives the columns of a 4x4 membrane keypad and samples its rows.
// - Debounces the result and emits one 4-bit key code per debounced press.
// - Produces the code stream that the adder datapath and 7-seg display consume as operand input.
// - Sits between the board keypad pins and the system top; replaces direct 4-bit button strapping.
// PARAMETERS
// - SCAN_DIV        default 50_000  clk cycles each column is driven; must be >= 4
// - DEBOUNCE_SCANS  default 4       consecutive identical full scans needed to accept or release a key; >= 1
// PORTS
// - clk        in   1  system clock
// - rst        in   1  synchronous reset, active-high
// - row_in     in   4  keypad rows, active-low, pulled up on board; asynchronous to clk
// - col_out    out  4  column strobes, one-cold, active-low
// - key_code   out  4  last accepted key code; held until the next accept
// - key_valid  out  1  1-cycle pulse when a new key is accepted
// - key_held   out  1  high while the accepted key remains debounced-pressed
// BEHAVIOUR
// - Reset: col_out=4'b1110 (col 0), key_code=0, key_valid=0, key_held=0, all counters=0, FSM=IDLE.
// - Reset mid-scan or mid-press discards all state. The first key after reset must be freshly debounced.
// - Sync: row_in passes through a 2-FF synchronizer before any use.
// - Column timing:
//   - dwell counter runs 0..SCAN_DIV-1.
//   - At dwell==SCAN_DIV-1 the synced rows are sampled for the current column, then col_out advances.
//   - Column order: 0->1->2->3->0.
//   - One full scan = 4*SCAN_DIV cycles; the scan ends at the col-3 sample.
// - Per-scan result (latched at scan end):
//   - NONE: no row low in any column.
//   - SINGLE(r,c): exactly one row low in exactly one column.
//   - MULTI: anything else, including ghosting.
// - Code map (row r, col c), from the shared table:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: E(*) 0 F(#) D
// - FSM, evaluated once per scan end:
//   - IDLE:
//     - SINGLE -> DEBOUNCE, cand=(r,c), cnt=1.
//     - NONE or MULTI: stay.
//   - DEBOUNCE:
//     - SINGLE equal to cand: cnt++.
//     - When cnt reaches DEBOUNCE_SCANS -> PRESSED. key_code=map(cand) and key_valid=1 on the following clk.
//     - SINGLE different from cand: restart with the new cand, cnt=1.
//     - NONE or MULTI -> IDLE.
//   - PRESSED:
//     - key_held=1.
//     - NONE -> RELEASE, cnt=1.
//     - SINGLE same or MULTI: stay; a second key never generates a press.
//     - SINGLE different: stay; the new key needs a full release first.
//   - RELEASE:
//     - NONE: cnt++. At DEBOUNCE_SCANS -> IDLE, key_held=0.
//     - Anything else -> PRESSED, cnt=0, no new key_valid.
// - DEBOUNCE_SCANS=1: accept on the first SINGLE scan. key_valid is still exactly one pulse.
// - key_valid never asserts in consecutive cycles.
// - Latency from stable press to key_valid: at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles.
// - Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_SCANS+1). No wrap is allowed past the limits.
// STRUCTURE
// - keypad_pkg holds:
//   - typedef enum {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t
//   - typedef struct {logic [1:0] row, col;} kp_pos_t
//   - localparam KEY_MAP[16] code table
//   - kp_scan_t result enum {NONE, SINGLE, MULTI}
// - One sub-module, kp_col_driver, owns the dwell counter, the column ring, and the sample strobe.
// - The top holds the synchronizer, scan accumulator, FSM and outputs.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; the bench models the matrix: row r low iff col c low and key (r,c) pressed)
// - Reset, no key, 10 scans: col_out cycles 1110,1101,1011,0111 every 4 clks; key_valid never 1; key_code=0.
// - Hold key (1,1) for 6 scans: exactly one key_valid pulse, key_code=4'h5, within 4*4*4+3 clks. key_held=1 until 3 NONE scans after release.
// - Bounce key (3,1) on/off every scan for 8 scans, then hold 4 scans: a single key_valid, key_code=4'h0.
// - Hold (0,0) until accepted, then add (2,2) for 5 scans, drop both: only one key_valid (code 4'h1); no pulse for 9.
// - Press (0,3) and (1,3) together for 6 scans: MULTI, no key_valid. Release, then press (3,3): key_code=4'hD.
// - Assert rst for 1 clk while (2,0) is in DEBOUNCE with cnt=2: all outputs return to reset values. A later 3-scan hold yields code 4'h7.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and the key-code table for the 4x4 keypad scanner.
//   kp_state_t : debounce FSM states
//   kp_pos_t   : (row, col) position of a single pressed key
//   kp_scan_t  : classification of one complete four-column scan
//   KEY_MAP    : code table indexed by {row, col}
package keypad_pkg;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } kp_pos_t;

   typedef enum logic [1:0] {NONE, SINGLE, MULTI} kp_scan_t;

   // Row-major keypad legend: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D"
   // with * encoded as E and # encoded as F.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [3:0] key_of(input kp_pos_t p);
      return KEY_MAP[{p.row, p.col}];
   endfunction

endpackage

// File: rtl/kp_col_driver.sv
// kp_col_driver
//   Column strobe generator. Each column is driven low for SCAN_DIV clocks;
//   sample_stb is high on the last dwell cycle of the current column, and the
//   ring advances to the next column on the following edge.
//   clk        : system clock
//   rst        : synchronous active-high reset (returns to column 0)
//   col_out    : one-cold active-low column strobes, registered
//   col_idx    : index of the column currently driven
//   sample_stb : rows should be sampled for col_idx this cycle
module kp_col_driver
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] col_out,
   output logic [1:0] col_idx,
   output logic       sample_stb
);

   localparam int            DW         = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_q,   col_d;
   logic [3:0]    strobe_q, strobe_d;

   always_comb begin
      dwell_d  = dwell_q + 1'b1;
      col_d    = col_q;
      strobe_d = strobe_q;
      if (dwell_q == DWELL_LAST) begin
         dwell_d  = '0;
         col_d    = col_q + 2'd1;
         // Rotate the single zero one place left: col 0 -> 1 -> 2 -> 3 -> 0.
         strobe_d = {strobe_q[2:0], strobe_q[3]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q  <= '0;
         col_q    <= 2'd0;
         strobe_q <= 4'b1110;
      end else begin
         dwell_q  <= dwell_d;
         col_q    <= col_d;
         strobe_q <= strobe_d;
      end
   end

   assign col_out    = strobe_q;
   assign col_idx    = col_q;
   assign sample_stb = (dwell_q == DWELL_LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a 4x4 membrane keypad, classifies each full scan, debounces over
//   DEBOUNCE_SCANS identical scans and emits one key code per press.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column strobes, one-cold active-low
//   key_code  : last accepted key code, held until the next accept
//   key_valid : one-cycle pulse when a new key is accepted
//   key_held  : high while the accepted key remains debounced-pressed
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int            CW       = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   // Count value whose next matching scan completes the debounce window.
   localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_SCANS - 1);

   logic [1:0] col_idx;
   logic       sample_stb;

   kp_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
      .clk        (clk),
      .rst        (rst),
      .col_out    (col_out),
      .col_idx    (col_idx),
      .sample_stb (sample_stb)
   );

   // Two-flop synchronizer on the raw rows.
   logic [3:0] row_meta_q, row_sync_q;

   // Scan accumulator: number of low row bits seen so far this scan
   // (saturating at 2, which already means MULTI) and the position of the
   // most recent lone low bit.
   logic [1:0] low_cnt_q,   low_cnt_d;
   kp_pos_t    pos_q,       pos_d;
   kp_scan_t   scan_res_q,  scan_res_d;
   kp_pos_t    scan_pos_q,  scan_pos_d;
   logic       scan_done_q, scan_done_d;

   // Debounce FSM and outputs.
   kp_state_t     state_q,     state_d;
   kp_pos_t       cand_q,      cand_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic [3:0]    key_code_q,  key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q,  key_held_d;

   logic [3:0] rows_low;
   logic [2:0] n_low;
   logic [1:0] low_row;
   logic [2:0] low_sum;
   logic [1:0] low_tot;

   always_comb begin
      rows_low = ~row_sync_q;
      n_low    = '0;
      low_row  = '0;
      for (int i = 0; i < 4; i++) begin
         if (rows_low[i]) begin
            n_low   = n_low + 3'd1;
            low_row = 2'(i);
         end
      end
      low_sum = 3'(low_cnt_q) + n_low;
      low_tot = (low_sum >= 3'd2) ? 2'd2 : low_sum[1:0];

      low_cnt_d   = low_cnt_q;
      pos_d       = pos_q;
      scan_res_d  = scan_res_q;
      scan_pos_d  = scan_pos_q;
      scan_done_d = 1'b0;
      if (sample_stb) begin
         if (n_low == 3'd1) begin
            pos_d = '{row: low_row, col: col_idx};
         end
         if (col_idx == 2'd3) begin
            // Column 3 closes the scan: publish the result and start afresh.
            scan_done_d = 1'b1;
            low_cnt_d   = 2'd0;
            scan_pos_d  = pos_d;
            scan_res_d  = (low_tot == 2'd0) ? NONE :
                          (low_tot == 2'd1) ? SINGLE : MULTI;
         end else begin
            low_cnt_d = low_tot;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (scan_done_q) begin
         unique case (state_q)
            IDLE: begin
               if (scan_res_q == SINGLE) begin
                  cand_d = scan_pos_q;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d     = PRESSED;
                     key_code_d  = key_of(scan_pos_q);
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     state_d = DEBOUNCE;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            DEBOUNCE: begin
               if (scan_res_q == SINGLE) begin
                  if (scan_pos_q == cand_q) begin
                     if (cnt_q == CNT_PRE) begin
                        state_d     = PRESSED;
                        key_code_d  = key_of(cand_q);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        cnt_d       = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else begin
                     cand_d = scan_pos_q;
                     cnt_d  = CNT_ONE;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            PRESSED: begin
               // Only a clean NONE scan starts the release; extra keys are ignored.
               if (scan_res_q == NONE) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d    = IDLE;
                     key_held_d = 1'b0;
                     cnt_d      = '0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            RELEASE: begin
               if (scan_res_q == NONE) begin
                  if (cnt_q == CNT_PRE) begin
                     state_d    = IDLE;
                     key_held_d = 1'b0;
                     cnt_d      = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         low_cnt_q   <= 2'd0;
         pos_q       <= '0;
         scan_res_q  <= NONE;
         scan_pos_q  <= '0;
         scan_done_q <= 1'b0;
         state_q     <= IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         row_meta_q  <= row_in;
         row_sync_q  <= row_meta_q;
         low_cnt_q   <= low_cnt_d;
         pos_q       <= pos_d;
         scan_res_q  <= scan_res_d;
         scan_pos_q  <= scan_pos_d;
         scan_done_q <= scan_done_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
//   Drives a modelled 4x4 key matrix one whole scan at a time and checks the
//   scanner against a scan-level behavioural model every cycle.
module tb_keypad_matrix_scanner;

   localparam int SD = 4;
   localparam int DS = 3;
   localparam int SCAN_CYC = 4 * SD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   always #5 clk = ~clk;

   keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Key matrix: bit r*4+c set means key (r,c) is pressed; row r reads low
   // when its column is strobed and the key is down.
   logic [15:0] pressed = '0;
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
   end

   int cyc = 0;      // clock edges since reset release
   int abs_cyc = 0;
   always @(posedge clk) begin
      abs_cyc <= abs_cyc + 1;
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int vectors = 0;
   int errors  = 0;

   task automatic cmp(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0d cyc=%0d got=%0h expected=%0h", nm, abs_cyc, cyc, act, exp);
      end
   endtask

   // Code of key index k from the printed keypad legend.
   function automatic int code_of(input int k);
      int r, c;
      r = k / 4;
      c = k % 4;
      if (c == 3) return 10 + r;            // A B C D down the last column
      if (r < 3)  return 3 * r + c + 1;     // digits 1..9
      if (c == 0) return 14;                // *
      if (c == 1) return 0;
      return 15;                            // #
   endfunction

   logic [15:0] keys_at [0:1023];

   // Scan-level model state.
   bit  armed;
   int  run_key, run_len, none_len;
   int  exp_code;
   bit  exp_held, exp_valid, prev_valid;
   logic [3:0] exp_col;
   int  vld_count, last_code, last_vld_abs;

   task automatic model_scan(input logic [15:0] k);
      int n, key;
      n = $countones(k);
      key = -1;
      for (int i = 0; i < 16; i++) if (k[i]) key = i;
      if (armed) begin
         if (n == 1) begin
            if (key == run_key) run_len++;
            else begin run_key = key; run_len = 1; end
            if (run_len == DS) begin
               exp_valid = 1'b1;
               exp_code  = code_of(key);
               armed     = 1'b0;
               none_len  = 0;
            end
         end else begin
            run_key = -1;
            run_len = 0;
         end
      end else begin
         if (n == 0) begin
            none_len++;
            if (none_len == DS) begin
               armed   = 1'b1;
               run_key = -1;
               run_len = 0;
            end
         end else begin
            none_len = 0;
         end
      end
      exp_held = !armed;
   endtask

   always @(negedge clk) begin
      exp_valid = 1'b0;
      if (cyc == 0) begin
         armed = 1'b1; run_key = -1; run_len = 0; none_len = 0;
         exp_code = 0; exp_held = 1'b0; prev_valid = 1'b0;
      end else if ((cyc % SCAN_CYC) == 1 && cyc > SCAN_CYC) begin
         model_scan(keys_at[(cyc - 1) / SCAN_CYC]);
      end
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
      cmp("col_out",   int'(col_out),   int'(exp_col));
      cmp("key_valid", int'(key_valid), int'(exp_valid));
      cmp("key_code",  int'(key_code),  exp_code);
      cmp("key_held",  int'(key_held),  int'(exp_held));
      cmp("valid_gap", int'(prev_valid && key_valid), 0);
      prev_valid = key_valid;
      if (key_valid) begin
         vld_count++;
         last_code    = int'(key_code);
         last_vld_abs = abs_cyc;
         $display("key accepted: code=%h at t=%0d", key_code, abs_cyc);
      end
   end

   // Stimulus: every task below starts and ends on a scan-boundary negedge.
   int sidx = 0;

   task automatic scan(input logic [15:0] k);
      pressed = k;
      sidx++;
      keys_at[sidx] = k;
      repeat (SCAN_CYC) @(negedge clk);
   endtask

   task automatic scans(input logic [15:0] k, input int n);
      for (int i = 0; i < n; i++) scan(k);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sidx = 0;
      @(negedge clk);
   endtask

   function automatic logic [15:0] kbit(input int r, input int c);
      return 16'(1) << (r * 4 + c);
   endfunction

   int press_abs;
   logic [15:0] prev_keys;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Idle scanning.
      vld_count = 0;
      scans('0, 10);
      cmp("idle_pulses", vld_count, 0);
      cmp("idle_code", int'(key_code), 0);

      // Clean press of (1,1) -> '5', then release.
      vld_count = 0;
      press_abs = abs_cyc;
      scans(kbit(1, 1), 6);
      cmp("k5_pulses", vld_count, 1);
      cmp("k5_code", last_code, 5);
      cmp("k5_latency_ok", int'((last_vld_abs - press_abs) <= 4*SD*(DS+1)+3), 1);
      scans('0, 3);
      cmp("k5_held_during_release", int'(key_held), 1);
      scan('0);
      cmp("k5_held_after_release", int'(key_held), 0);

      // Bouncing (3,1) then a stable hold -> '0'.
      vld_count = 0;
      for (int i = 0; i < 8; i++) scan((i % 2 == 0) ? kbit(3, 1) : 16'h0);
      scans(kbit(3, 1), 4);
      scans('0, 4);
      cmp("k0_pulses", vld_count, 1);
      cmp("k0_code", last_code, 0);

      // (0,0) accepted, then a second key joins: no second press.
      vld_count = 0;
      scans(kbit(0, 0), 3);
      scans(kbit(0, 0) | kbit(2, 2), 5);
      scans('0, 4);
      cmp("k1_pulses", vld_count, 1);
      cmp("k1_code", last_code, 1);

      // Two keys in one column never accept; a following single key does.
      vld_count = 0;
      scans(kbit(0, 3) | kbit(1, 3), 6);
      scans('0, 4);
      cmp("multi_pulses", vld_count, 0);
      scans(kbit(3, 3), 4);
      scans('0, 4);
      cmp("kD_pulses", vld_count, 1);
      cmp("kD_code", last_code, 13);

      // Reset while (2,0) is two scans into its debounce window.
      scans(kbit(2, 0), 2);
      repeat (2) @(negedge clk);
      pulse_reset();
      cmp("rst_col", int'(col_out), 4'b1110);
      cmp("rst_code", int'(key_code), 0);
      cmp("rst_held", int'(key_held), 0);
      cmp("rst_valid", int'(key_valid), 0);
      vld_count = 0;
      scans(kbit(2, 0), 3);
      scan('0);
      cmp("k7_pulses", vld_count, 1);
      cmp("k7_code", last_code, 7);
      scans('0, 3);

      // Randomized scan sequences against the model.
      prev_keys = '0;
      for (int i = 0; i < 120; i++) begin
         logic [15:0] k;
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel <= 2)      k = '0;
         else if (sel <= 6) k = prev_keys;
         else if (sel <= 8) k = kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else               k = kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                              | kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if (sel > 2 && sel <= 6 && prev_keys == '0)
            k = kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         scan(k);
         prev_keys = k;
      end
      scans('0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
